// File: rtl/counter_sweep_pkg.sv
// Shared types and constants for the counter sweep sequencer and its counter datapath.
package counter_sweep_pkg;

    localparam int unsigned COUNT_W = 3;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } sweep_mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2
    } sweep_state_e;

endpackage

// File: rtl/up_down_counter.sv
// Wrapping up/down counter with terminal-value flags; synchronous active-high reset.
module up_down_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] count,
    output logic         at_max,
    output logic         at_min
);
    import counter_sweep_pkg::*;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == {W{1'b1}});
    assign at_min = (count_q == '0);

endmodule

// File: rtl/counter_sweep_ctrl.sv
// Sequences one up_down_counter through up, down or ping-pong sweeps for a commanded
// number of passes, with hold, abort and a one-cycle done/err report.
module counter_sweep_ctrl #(
    parameter int unsigned COUNT_W = 3,
    parameter int unsigned PASS_W  = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_mode,
    input  logic [PASS_W-1:0]  cmd_passes,
    input  logic               hold,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [PASS_W-1:0]  pass_cnt,
    output logic [COUNT_W-1:0] count,
    output logic               at_max,
    output logic               at_min
);
    import counter_sweep_pkg::*;

    localparam logic [COUNT_W-1:0] CntTermUp = COUNT_W'(COUNT_MAX - 3'd1);
    localparam logic [COUNT_W-1:0] CntTermDn = COUNT_W'(1);

    sweep_state_e      state_q, state_d;
    sweep_mode_e       mode_q, mode_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              clr, cnt_en, cnt_up, step_done;
    logic [PASS_W-1:0] pass_inc;

    assign pass_inc = pass_cnt_q + 1'b1;

    always_comb begin
        unique case (mode_q)
            MODE_UP:   cnt_up = 1'b1;
            MODE_DOWN: cnt_up = 1'b0;
            default:   cnt_up = dir_q;
        endcase
    end

    // Abort freezes the counter, so it also gates the enable.
    assign cnt_en    = (state_q == S_RUN) && !hold && !abort;
    assign clr       = (state_q == S_CLEAR);
    assign step_done = cnt_en && ((cnt_up && count == CntTermUp) ||
                                  (!cnt_up && count == CntTermDn));

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        passes_d   = passes_q;
        pass_cnt_d = pass_cnt_q;
        dir_d      = dir_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    mode_d     = sweep_mode_e'(cmd_mode);
                    passes_d   = cmd_passes;
                    pass_cnt_d = '0;
                    dir_d      = 1'b1;
                    if (sweep_mode_e'(cmd_mode) == MODE_RSVD) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (cmd_passes == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (step_done) begin
                    pass_cnt_d = pass_inc;
                    dir_d      = !dir_q;
                    if (pass_inc == passes_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= MODE_UP;
            passes_q   <= '0;
            pass_cnt_q <= '0;
            dir_q      <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    up_down_counter #(
        .W (COUNT_W)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset | clr),
        .en     (cnt_en),
        .up     (cnt_up),
        .count  (count),
        .at_max (at_max),
        .at_min (at_min)
    );

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign pass_cnt  = pass_cnt_q;

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer that owns one `up_down_counter` instance and drives it through commanded sweeps: up, down or ping-pong, for a programmed number of passes. It generates the counter's enable, direction and clear from a valid/ready command interface, and reports progress, completion and errors. It sits between the loop's command source and the 3-bit counter datapath, and is the only agent allowed to drive that counter.

## Interface
- `COUNT_W`, 3: counter width; fixed to match `up_down_counter`.
- `PASS_W`, 4: width of the pass count.
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; also resets the counter instance.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; accept = `cmd_valid & cmd_ready` at an edge.
- `cmd_mode` in 2: 0 UP, 1 DOWN, 2 PINGPONG, 3 reserved.
- `cmd_passes` in PASS_W: number of passes to run.
- `hold` in 1: pauses stepping while high in RUN.
- `abort` in 1: terminates a CLEAR or RUN immediately.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse at command end.
- `err` out 1: valid with `done`; otherwise 0.
- `pass_cnt` out PASS_W: passes completed in the current or last command.
- `count` out COUNT_W: counter value, passed through.
- `at_max` out 1: counter flag, passed through.
- `at_min` out 1: counter flag, passed through.

## Operation
- **States:** IDLE, CLEAR, RUN.
- **IDLE**
  - `cmd_ready`=1; counter enable=0.
  - On accept: latch mode and passes, and clear `pass_cnt`.
  - If mode=3 or passes=0, stay in IDLE and pulse `done` the next cycle, with `err`=1 for mode=3 and `err`=0 for passes=0.
  - Otherwise go to CLEAR.
- **CLEAR:** assert the counter's clear (counter reset = `reset | clr`) for exactly one cycle, then go to RUN. Count is 0 after that edge.
- **RUN:** counter enable = `!hold`. Direction:
  - UP mode: 1.
  - DOWN mode: 0.
  - PINGPONG: starts at 1 and toggles at each pass completion.
- **Pass completion** is an enabled step that lands on the terminal value:
  - direction 1 with count=max-1 (next count is max);
  - direction 0 with count=1 (next count is 0).
  - `pass_cnt` increments on that edge.
- **Pass lengths:**
  - UP: the first pass is 7 steps (0→7); each later pass is 8 steps, because it wraps 7→0 first.
  - DOWN: the first step wraps 0→7 and is not a completion, so the first pass is 8 steps; later passes are 8 steps each.
  - PINGPONG: every pass is 7 steps, alternating 0→7 and 7→0.
- **Final pass:** when the incremented `pass_cnt` equals the latched passes, go to IDLE on that edge and pulse `done` with `err`=0. The counter holds its value.
- **Abort** in CLEAR or RUN: go to IDLE on that edge and pulse `done` with `err`=1. `pass_cnt` and count freeze. Abort has priority over a simultaneous final pass completion. Abort is ignored in IDLE.
- **`hold` during CLEAR** has no effect; the clear always completes.

## Timing
- **Reset values:** `cmd_ready`=1, `busy`=0, `done`=0, `err`=0, `pass_cnt`=0, `count`=0, `at_min`=1, `at_max`=0. State is IDLE.
- `done` and `err` are registered: high exactly in the first IDLE cycle after termination.
- `cmd_ready` is 1 during the `done` cycle, so back-to-back commands are legal.
- **Latency:** from the accept edge E0, CLEAR covers E0–E1, the first step occurs at E2, and RUN with UP and passes=1 ends at E8. `done`=1 in the cycle after E8, with count=7 and `at_max`=1.
- Each `hold` cycle in RUN adds exactly one cycle with no step.
- **Reset mid-command:** all outputs return to their reset values at the next edge. No `done` pulse is generated.
- Command inputs are sampled only at the accept edge; changes afterwards are ignored.

## Structure
- **Package `counter_sweep_pkg`:**
  - `sweep_mode_e` (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_RSVD);
  - `sweep_state_e` (S_IDLE, S_CLEAR, S_RUN);
  - localparams `COUNT_W`=3 and `COUNT_MAX`=7.
- **Single sub-module:** `up_down_counter`, instantiated as `u_cnt`. Its reset is driven by `reset | clr`, its enable and direction by the FSM, and its flags are exported unchanged.
- The pass-completion detect (terminal-minus-one compare) is combinational from count, direction and enable.

## Test plan
- Reset, then UP with passes=1 → `done` in the cycle after edge E8; count=7, `at_max`=1, `pass_cnt`=1, `err`=0.
- DOWN with passes=2 → count path 0,7,6…0 (pass 1, 8 steps), then 7…0 (pass 2, 8 steps); `done` with `pass_cnt`=2 and count=0.
- PINGPONG with passes=3 and `hold` high for 3 cycles mid-pass → pass ends at 7, 0, 7; completion delayed by exactly 3 cycles; final count=7.
- Abort during RUN at count=4 → `done`=1 and `err`=1 the next cycle; count stays 4; `busy`=0.
- Mode=3 and passes=0 commands → no stepping, `done` the cycle after accept, `err`=1 and 0 respectively. Then a back-to-back UP command accepted in the `done` cycle runs normally.
- Synchronous reset asserted mid-RUN (count=5) → next edge: count=0, `at_min`=1, `busy`=0, `done`=0.
